canvas_buffer: RTL and testbench

//  32x32 one-bit drawing canvas between the cursor/button logic and the VGA

---
 rtl/canvas_buffer.sv | 120 ++++++++++++
 tb/tb_canvas_buffer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/canvas_buffer.sv
// 32x32 one-bit drawing canvas: cursor-driven set/clear, registered VGA read
// port, live count of set cells and a one-cell-per-cycle clear sweep.
module canvas_buffer #(
  parameter int GRID_BITS = 5,
  parameter int CNT_W     = 11
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 draw,
  input  logic                 erase,
  input  logic [GRID_BITS-1:0] cursor_x,
  input  logic [GRID_BITS-1:0] cursor_y,
  input  logic                 clear_all,
  input  logic [GRID_BITS-1:0] rd_x,
  input  logic [GRID_BITS-1:0] rd_y,
  output logic                 rd_pixel,
  output logic                 rd_cursor,
  output logic                 busy,
  output logic [CNT_W-1:0]     set_count
);

  localparam int ADDR_W = 2 * GRID_BITS;
  localparam int CELLS  = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state;
  logic [ADDR_W-1:0]    sweep_addr;
  logic [1:0]           draw_sync;
  logic [1:0]           erase_sync;
  logic [GRID_BITS-1:0] cursor_x_meta, cursor_x_s;
  logic [GRID_BITS-1:0] cursor_y_meta, cursor_y_s;

  logic                 mem [CELLS];

  logic                 wr_en;
  logic                 wr_data;
  logic [ADDR_W-1:0]    wr_addr;
  logic [ADDR_W-1:0]    cursor_addr;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 wr_old;

  assign cursor_addr = {cursor_y_s, cursor_x_s};
  assign rd_addr     = {rd_y, rd_x};
  assign busy        = (state == CLEAR);
  assign wr_old      = mem[wr_addr];

  // One write port shared by the sweep and the synced draw/erase buttons.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = 1'b0;
    wr_addr = cursor_addr;
    if (!clr) begin
      if (state == CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = sweep_addr;
      end else if (!clear_all) begin
        if (erase_sync[1]) begin
          wr_en = 1'b1;
        end else if (draw_sync[1]) begin
          wr_en   = 1'b1;
          wr_data = 1'b1;
        end
      end
    end
  end

  // NOTE: the cell array has no reset; the clear sweep that follows reset blanks it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // NOTE: all state updates use non-blocking assignments so reads see pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      state         <= CLEAR;
      sweep_addr    <= '0;
      set_count     <= '0;
      rd_pixel      <= 1'b0;
      rd_cursor     <= 1'b0;
      draw_sync     <= '0;
      erase_sync    <= '0;
      cursor_x_meta <= '0;
      cursor_x_s    <= '0;
      cursor_y_meta <= '0;
      cursor_y_s    <= '0;
    end else begin
      draw_sync     <= {draw_sync[0], draw};
      erase_sync    <= {erase_sync[0], erase};
      cursor_x_meta <= cursor_x;
      cursor_x_s    <= cursor_x_meta;
      cursor_y_meta <= cursor_y;
      cursor_y_s    <= cursor_y_meta;

      rd_pixel  <= (state == CLEAR) ? 1'b0 : mem[rd_addr];
      rd_cursor <= (rd_addr == cursor_addr);

      case (state)
        IDLE: begin
          if (clear_all) begin
            state      <= CLEAR;
            sweep_addr <= '0;
            set_count  <= '0;
          end else if (wr_en && wr_data && !wr_old) begin
            set_count <= set_count + 1'b1;
          end else if (wr_en && !wr_data && wr_old) begin
            set_count <= set_count - 1'b1;
          end
        end
        CLEAR: begin
          sweep_addr <= sweep_addr + 1'b1;
          if (sweep_addr == ADDR_W'(CELLS - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_canvas_buffer.sv
// Randomized and directed bench for canvas_buffer against a cell-array reference
// model that tracks inputs by the cycle they were applied.
module tb_canvas_buffer;

  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        clr, draw, erase, clear_all;
  logic [4:0]  cursor_x, cursor_y, rd_x, rd_y;
  logic        rd_pixel, rd_cursor, busy;
  logic [10:0] set_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  canvas_buffer #(.GRID_BITS(5), .CNT_W(11)) dut (
    .clk(clk), .clr(clr), .draw(draw), .erase(erase),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .clear_all(clear_all),
    .rd_x(rd_x), .rd_y(rd_y), .rd_pixel(rd_pixel), .rd_cursor(rd_cursor),
    .busy(busy), .set_count(set_count)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: canvas contents, inputs seen at the last two edges, and
  // how many sweep cycles remain. A clear blanks the model canvas at once,
  // since reads are forced to 0 and writes are dropped while it runs.
  typedef struct packed {
    logic       draw;
    logic       erase;
    logic [4:0] x;
    logic [4:0] y;
  } in_t;

  bit  canvas [N];
  in_t hist [2];
  bit  clearing;
  int  remaining;
  bit  exp_pix, exp_cur;

  function automatic int popcount();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(canvas[i]);
    return c;
  endfunction

  task automatic blank_model();
    for (int i = 0; i < N; i++) canvas[i] = 1'b0;
  endtask

  task automatic model_edge();
    in_t old;
    if (clr) begin
      clearing  = 1'b1;
      remaining = N;
      blank_model();
      hist[0]   = '0;
      hist[1]   = '0;
      exp_pix   = 1'b0;
      exp_cur   = 1'b0;
    end else begin
      old     = hist[1];
      exp_pix = clearing ? 1'b0 : canvas[{rd_y, rd_x}];
      exp_cur = (rd_x == old.x) && (rd_y == old.y);
      if (clearing) begin
        remaining--;
        if (remaining == 0) clearing = 1'b0;
      end else if (clear_all) begin
        clearing  = 1'b1;
        remaining = N;
        blank_model();
      end else if (old.erase) begin
        canvas[{old.y, old.x}] = 1'b0;
      end else if (old.draw) begin
        canvas[{old.y, old.x}] = 1'b1;
      end
      hist[1] = hist[0];
      hist[0] = '{draw: draw, erase: erase, x: cursor_x, y: cursor_y};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("busy", busy, clearing);
    check("set_count", set_count, clearing ? 0 : popcount());
    check("rd_pixel", rd_pixel, exp_pix);
    check("rd_cursor", rd_cursor, exp_cur);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic paint(input int x, input int y, input bit d, input bit e);
    cursor_x = 5'(x);
    cursor_y = 5'(y);
    draw = d;
    erase = e;
    run(4);
    draw = 1'b0;
    erase = 1'b0;
    run(3);
  endtask

  int bc;

  initial begin
    clr = 1'b1; draw = 1'b0; erase = 1'b0; clear_all = 1'b0;
    cursor_x = '0; cursor_y = '0; rd_x = '0; rd_y = '0;

    // Reset: busy exactly 1024 cycles, then every cell reads 0.
    tick();
    clr = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 2000) begin tick(); bc++; end
    check("t1_busy_len", bc, 1024);
    check("t1_count", set_count, 0);
    for (int i = 0; i < N; i++) begin
      {rd_y, rd_x} = 10'(i);
      tick();
    end

    // Held draw on one cell counts once.
    cursor_x = 5'd3; cursor_y = 5'd7; draw = 1'b1;
    run(6);
    draw = 1'b0;
    run(3);
    check("t2_count", set_count, 1);
    rd_x = 5'd3; rd_y = 5'd7;
    tick();
    check("t2_pixel", rd_pixel, 1);
    check("t2_cursor", rd_cursor, 1);

    // Erase wins over draw.
    paint(31, 31, 1'b1, 1'b0);
    check("t3_count_set", set_count, 2);
    paint(31, 31, 1'b1, 1'b1);
    check("t3_count_clr", set_count, 1);
    rd_x = 5'd31; rd_y = 5'd31;
    tick();
    check("t3_pixel", rd_pixel, 0);

    // Clear sweep; draws during busy are dropped.
    for (int i = 0; i < 5; i++) paint(10 + i, 20 - i, 1'b1, 1'b0);
    check("t4_count_pre", set_count, 6);
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    check("t4_count_zero", set_count, 0);
    bc = 0;
    while (busy === 1'b1 && bc < 2000) begin
      if (bc < 1000) begin
        draw = ($urandom_range(0, 3) == 0);
        cursor_x = 5'($urandom); cursor_y = 5'($urandom);
        clear_all = ($urandom_range(0, 50) == 0);
      end else begin
        draw = 1'b0;
        clear_all = 1'b0;
      end
      rd_x = 5'($urandom); rd_y = 5'($urandom);
      tick();
      bc++;
    end
    draw = 1'b0; clear_all = 1'b0;
    check("t4_busy_len", bc, 1024);
    run(3);
    check("t4_count_after", set_count, 0);

    // Same-edge write and read of (0,0) returns the old value.
    cursor_x = 5'd0; cursor_y = 5'd0; rd_x = 5'd0; rd_y = 5'd0;
    run(3);
    draw = 1'b1;
    tick();
    draw = 1'b0;
    tick();
    tick();
    check("t5_old", rd_pixel, 0);
    tick();
    check("t5_new", rd_pixel, 1);

    // Fill the whole canvas, redraw one cell, erase one cell.
    draw = 1'b1;
    for (int i = 0; i < N; i++) begin
      {cursor_y, cursor_x} = 10'(i);
      rd_x = 5'($urandom); rd_y = 5'($urandom);
      run(4);
    end
    draw = 1'b0;
    run(3);
    check("t6_full", set_count, 1024);
    paint(5, 5, 1'b1, 1'b0);
    check("t6_redraw", set_count, 1024);
    paint(9, 2, 1'b0, 1'b1);
    check("t6_erase", set_count, 1023);

    // Random mix on a small region so draws and erases collide.
    for (int i = 0; i < 3000; i++) begin
      if (i % 5 == 0) begin
        cursor_x = 5'($urandom_range(0, 7));
        cursor_y = 5'($urandom_range(0, 7));
        draw = $urandom_range(0, 1) == 1;
        erase = $urandom_range(0, 3) == 0;
      end
      rd_x = 5'($urandom_range(0, 7));
      rd_y = 5'($urandom_range(0, 7));
      clear_all = ($urandom_range(0, 400) == 0);
      clr = ($urandom_range(0, 1500) == 0);
      tick();
    end
    clr = 1'b0; clear_all = 1'b0; draw = 1'b0; erase = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 2000) begin tick(); bc++; end
    check("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
